// File: rtl/cmp_alarm_monitor_if.sv
// Bus between the comparator front end and the alarm monitor: qualified
// comparator flags in, debounced alarm status out.
`timescale 1ns/1ps
interface cmp_alarm_monitor_if #(
  parameter int CNT_W = 8
);
  logic             sample_valid;
  logic             less;
  logic             equal;
  logic             greater;
  logic             alarm;
  logic             alarm_rise;
  logic             alarm_fall;
  logic [CNT_W-1:0] alarm_count;
  logic             flag_error;

  // Producer of comparator samples, consumer of alarm status.
  modport master (
    output sample_valid, less, equal, greater,
    input  alarm, alarm_rise, alarm_fall, alarm_count, flag_error
  );

  // The monitor itself.
  modport slave (
    input  sample_valid, less, equal, greater,
    output alarm, alarm_rise, alarm_fall, alarm_count, flag_error
  );
endinterface

// File: rtl/cmp_alarm_monitor.sv
// Debounced over-threshold alarm driven by a magnitude comparator's
// less/equal/greater flags. Raises after SET_COUNT consecutive 'greater'
// samples, drops after CLR_COUNT consecutive 'less' samples, counts alarm
// entries (saturating) and flags malformed comparator outputs.
`timescale 1ns/1ps
module cmp_alarm_monitor #(
  parameter int SET_COUNT = 3,
  parameter int CLR_COUNT = 3,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  cmp_alarm_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ARMING   = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_t;

  localparam logic [3:0] SET_N = 4'(SET_COUNT);
  localparam logic [3:0] CLR_N = 4'(CLR_COUNT);

  state_t           r_state;
  logic [3:0]       r_run;
  logic             r_alarm;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_count;
  logic             r_flag_error;

  state_t     w_state_nxt;
  logic [3:0] w_run_nxt;
  logic [3:0] w_run_inc;
  logic [2:0] w_flags;
  logic       w_onehot;
  logic       w_accept;
  logic       w_bad;
  logic       w_enter_alarm;
  logic       w_leave_alarm;

  // Classify the incoming sample: accepted (one-hot) or malformed.
  always_comb begin
    w_flags  = {bus.less, bus.equal, bus.greater};
    w_onehot = (w_flags == 3'b001) || (w_flags == 3'b010) || (w_flags == 3'b100);
    w_accept = bus.sample_valid & w_onehot;
    w_bad    = bus.sample_valid & ~w_onehot;
  end

  // State and run counter register; a reset discards any streak in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= NORMAL;
      r_run   <= 4'd0;
    end else begin
      // NOTE: state is updated with <= so every register samples the same pre-edge values.
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Next-state logic: streak counting only advances on accepted samples.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_run_nxt     = r_run;
    w_enter_alarm = 1'b0;
    w_leave_alarm = 1'b0;
    w_run_inc     = r_run + 4'd1;
    if (w_accept) begin
      case (r_state)
        NORMAL: begin
          if (bus.greater) begin
            if (SET_N == 4'd1) begin
              w_state_nxt   = ALARM;
              w_run_nxt     = 4'd0;
              w_enter_alarm = 1'b1;
            end else begin
              w_state_nxt = ARMING;
              w_run_nxt   = 4'd1;
            end
          end
        end
        ARMING: begin
          if (bus.greater) begin
            if (w_run_inc == SET_N) begin
              w_state_nxt   = ALARM;
              w_run_nxt     = 4'd0;
              w_enter_alarm = 1'b1;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            w_state_nxt = NORMAL;
            w_run_nxt   = 4'd0;
          end
        end
        ALARM: begin
          if (bus.less) begin
            if (CLR_N == 4'd1) begin
              w_state_nxt   = NORMAL;
              w_run_nxt     = 4'd0;
              w_leave_alarm = 1'b1;
            end else begin
              w_state_nxt = CLEARING;
              w_run_nxt   = 4'd1;
            end
          end
        end
        CLEARING: begin
          if (bus.less) begin
            if (w_run_inc == CLR_N) begin
              w_state_nxt   = NORMAL;
              w_run_nxt     = 4'd0;
              w_leave_alarm = 1'b1;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            // Streak of 'less' broken: back to full alarm, no new entry counted.
            w_state_nxt = ALARM;
            w_run_nxt   = 4'd0;
          end
        end
        default: begin
          w_state_nxt = NORMAL;
          w_run_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Registered outputs: alarm level, edge pulses, entry counter, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the asynchronous reset clears every output register, so status is defined before the first clock.
    if (reset) begin
      r_alarm      <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_count      <= '0;
      r_flag_error <= 1'b0;
    end else begin
      r_alarm <= (w_state_nxt == ALARM) || (w_state_nxt == CLEARING);
      r_rise  <= w_enter_alarm;
      r_fall  <= w_leave_alarm;
      if (w_enter_alarm && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
      if (w_bad) begin
        r_flag_error <= 1'b1;
      end
    end
  end

  assign bus.alarm       = r_alarm;
  assign bus.alarm_rise  = r_rise;
  assign bus.alarm_fall  = r_fall;
  assign bus.alarm_count = r_count;
  assign bus.flag_error  = r_flag_error;

endmodule

// File: tb/tb_cmp_alarm_monitor.sv
// Bench for cmp_alarm_monitor: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a streak-counting reference model predicts every output.
`timescale 1ns/1ps
module tb_cmp_alarm_monitor;

  localparam int SET = 3;
  localparam int CLR = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmp_alarm_monitor_if #(.CNT_W(8)) bus8 ();
  cmp_alarm_monitor_if #(.CNT_W(2)) bus2 ();

  cmp_alarm_monitor #(.SET_COUNT(SET), .CLR_COUNT(CLR), .CNT_W(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  cmp_alarm_monitor #(.SET_COUNT(SET), .CLR_COUNT(CLR), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: alarm level plus lengths of the current greater/less streaks.
  bit m_alarm;
  int m_gstreak;
  int m_lstreak;
  bit m_rise;
  bit m_fall;
  int m_cnt8;
  int m_cnt2;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_alarm   = 1'b0;
    m_gstreak = 0;
    m_lstreak = 0;
    m_rise    = 1'b0;
    m_fall    = 1'b0;
    m_cnt8    = 0;
    m_cnt2    = 0;
    m_err     = 1'b0;
  endtask

  task automatic model_sample(input logic v, input logic l, input logic e, input logic g);
    int ones;
    ones   = int'(l) + int'(e) + int'(g);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (v && ones != 1) begin
      m_err = 1'b1;
    end else if (v) begin
      if (!m_alarm) begin
        if (g) begin
          m_gstreak++;
          if (m_gstreak == SET) begin
            m_alarm   = 1'b1;
            m_gstreak = 0;
            m_rise    = 1'b1;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
          end
        end else begin
          m_gstreak = 0;
        end
      end else begin
        if (l) begin
          m_lstreak++;
          if (m_lstreak == CLR) begin
            m_alarm   = 1'b0;
            m_lstreak = 0;
            m_fall    = 1'b1;
          end
        end else begin
          m_lstreak = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".alarm8"},  32'(bus8.alarm),       32'(m_alarm));
    check({ctx, ".rise8"},   32'(bus8.alarm_rise),  32'(m_rise));
    check({ctx, ".fall8"},   32'(bus8.alarm_fall),  32'(m_fall));
    check({ctx, ".count8"},  32'(bus8.alarm_count), 32'(m_cnt8));
    check({ctx, ".err8"},    32'(bus8.flag_error),  32'(m_err));
    check({ctx, ".alarm2"},  32'(bus2.alarm),       32'(m_alarm));
    check({ctx, ".rise2"},   32'(bus2.alarm_rise),  32'(m_rise));
    check({ctx, ".fall2"},   32'(bus2.alarm_fall),  32'(m_fall));
    check({ctx, ".count2"},  32'(bus2.alarm_count), 32'(m_cnt2));
    check({ctx, ".err2"},    32'(bus2.flag_error),  32'(m_err));
  endtask

  task automatic drive(input logic v, input logic l, input logic e, input logic g);
    bus8.sample_valid = v; bus8.less = l; bus8.equal = e; bus8.greater = g;
    bus2.sample_valid = v; bus2.less = l; bus2.equal = e; bus2.greater = g;
  endtask

  // One clock with the given sample presented; outputs checked 1ns after the edge.
  task automatic step(input string ctx, input logic v, input logic l, input logic e, input logic g);
    drive(v, l, e, g);
    @(posedge clk);
    #1;
    model_sample(v, l, e, g);
    check_all(ctx);
  endtask

  task automatic gt(input string ctx);   step(ctx, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic lt(input string ctx);   step(ctx, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic eq(input string ctx);   step(ctx, 1'b1, 1'b0, 1'b1, 1'b0); endtask
  task automatic idle(input string ctx); step(ctx, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic mid_reset(input string ctx);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_cnt2 [5] = '{1, 2, 3, 3, 3};

  initial begin
    logic v, l, e, g;
    int   r;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all("T0_reset");
    @(negedge clk);
    reset = 1'b0;

    // T2: three greaters raise alarm, pulse for one cycle only.
    gt("T2_g1"); gt("T2_g2"); gt("T2_g3");
    check("T2_alarm_const", 32'(bus8.alarm), 32'd1);
    check("T2_count_const", 32'(bus8.alarm_count), 32'd1);
    idle("T2_after");
    check("T2_rise_drop", 32'(bus8.alarm_rise), 32'd0);

    // T1: reset while alarm is high, then progress toward a new alarm and reset mid-ARMING.
    mid_reset("T1_reset_alarm");
    gt("T1_g1"); gt("T1_g2");
    mid_reset("T1_reset_arming");
    gt("T1_post_g1");
    check("T1_no_alarm", 32'(bus8.alarm), 32'd0);

    // T3: an 'equal' breaks the streak.
    mid_reset("T3_reset");
    gt("T3_g1"); gt("T3_g2"); eq("T3_e"); gt("T3_g3"); gt("T3_g4");
    check("T3_still_low", 32'(bus8.alarm), 32'd0);
    gt("T3_g5");
    check("T3_raised", 32'(bus8.alarm), 32'd1);

    // T4: less streak broken by greater, then three lesses clear.
    lt("T4_l1"); lt("T4_l2"); gt("T4_g"); lt("T4_l3"); lt("T4_l4");
    check("T4_still_high", 32'(bus8.alarm), 32'd1);
    lt("T4_l5");
    check("T4_fall", 32'(bus8.alarm_fall), 32'd1);
    check("T4_count_same", 32'(bus8.alarm_count), 32'd1);
    idle("T4_after");

    // T5: malformed flags are flagged but leave the streak intact.
    gt("T5_g1");
    step("T5_bad_lg", 1'b1, 1'b1, 1'b0, 1'b1);
    check("T5_err_set", 32'(bus8.flag_error), 32'd1);
    gt("T5_g2"); gt("T5_g3");
    check("T5_streak_kept", 32'(bus8.alarm), 32'd1);
    mid_reset("T5_reset");
    step("T5_bad_000", 1'b1, 1'b0, 1'b0, 1'b0);
    step("T5_bad_111", 1'b1, 1'b1, 1'b1, 1'b1);
    idle("T5_sticky");
    check("T5_err_sticky", 32'(bus8.flag_error), 32'd1);

    // T6: saturation of the 2-bit counter, with gaps between samples.
    mid_reset("T6_reset");
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < SET; k++) begin gt("T6_g"); idle("T6_gap"); end
      check("T6_count2", 32'(bus2.alarm_count), 32'(exp_cnt2[c]));
      for (int k = 0; k < CLR; k++) begin lt("T6_l"); idle("T6_gap"); end
    end

    // Randomized traffic, biased toward completing streaks.
    mid_reset("R_reset0");
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 199) mid_reset("R_reset");
      v = ($urandom_range(0, 99) < 75);
      l = 1'b0; e = 1'b0; g = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 7);
        l = r[2]; e = r[1]; g = r[0];
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6)      begin if (m_alarm) l = 1'b1; else g = 1'b1; end
        else if (r < 8) e = 1'b1;
        else            begin if (m_alarm) g = 1'b1; else l = 1'b1; end
      end
      step("R", v, l, e, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
